// File: rtl/position_tracker_pkg.sv
// Shared odometry definitions: headings, FSM encodings and default geometry.
// The heading and state encodings are also used by the drive block.
package position_tracker_pkg;

    localparam int COORD_W            = 33;
    localparam int TICKS_PER_CELL_DEF = 20;
    localparam int DEBOUNCE_DEF       = 4;
    localparam int SETTLE_DEF         = 8;
    localparam int GRID_MAX_DEF       = 39;
    localparam int START_X_DEF        = 0;
    localparam int START_Y_DEF        = 0;

    localparam logic [1:0] ORI_N = 2'b00;
    localparam logic [1:0] ORI_E = 2'b01;
    localparam logic [1:0] ORI_W = 2'b10;
    localparam logic [1:0] ORI_S = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_MOVE   = 2'b01,
        ST_TURN   = 2'b10,
        ST_SETTLE = 2'b11
    } pt_state_e;

    function automatic logic [COORD_W-1:0] sat_coord(input logic [COORD_W-1:0] v,
                                                     input logic [COORD_W-1:0] lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/position_tracker_if.sv
// Bus between the drive/navigation side (master) and the position tracker (slave).
interface position_tracker_if;
    import position_tracker_pkg::*;

    logic               enc;
    logic               moving;
    logic               turning;
    logic [1:0]         cori;
    logic               load;
    logic [COORD_W-1:0] load_x;
    logic [COORD_W-1:0] load_y;
    logic [COORD_W-1:0] sX;
    logic [COORD_W-1:0] sY;
    logic               step;
    logic               clamped;

    modport master (
        output enc, moving, turning, cori, load, load_x, load_y,
        input  sX, sY, step, clamped
    );

    modport slave (
        input  enc, moving, turning, cori, load, load_x, load_y,
        output sX, sY, step, clamped
    );

endinterface

// File: rtl/position_tracker_enc_debounce.sv
// Encoder front end: 2-flop synchroniser, stability down-counter, rising-edge tick.
// The tick is registered, so it appears 2+DEBOUNCE cycles after the raw edge.
module position_tracker_enc_debounce #(
    parameter int DEBOUNCE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_enc,
    output logic o_tick
);

    localparam int            CW     = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(DEBOUNCE - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_tick;
    logic [CW-1:0] r_cnt;

    // r_cnt resets to 0 but is reloaded before any differing sample can reach it,
    // because r_sync2 is still 0 for the first cycle after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_tick  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_enc;
            r_sync2 <= r_sync1;
            r_tick  <= 1'b0;
            if (r_sync2 == r_level) begin
                r_cnt <= RELOAD;
            end else if (r_cnt == '0) begin
                r_level <= r_sync2;
                r_cnt   <= RELOAD;
                r_tick  <= r_sync2;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign o_tick = r_tick;

endmodule

// File: rtl/position_tracker.sv
// Wheel odometry: debounced encoder ticks, gated by the motion FSM, step grid coordinates.
//   state     | meaning
//   ST_IDLE   | not moving, ticks ignored, partial tick count kept
//   ST_MOVE   | ticks accumulate; a full cell of ticks steps along cori
//   ST_TURN   | turning, ticks discarded, tick count held at 0
//   ST_SETTLE | post-turn blanking for SETTLE cycles, ticks discarded
module position_tracker
    import position_tracker_pkg::*;
#(
    parameter int TICKS_PER_CELL = TICKS_PER_CELL_DEF,
    parameter int DEBOUNCE       = DEBOUNCE_DEF,
    parameter int SETTLE         = SETTLE_DEF,
    parameter int GRID_MAX       = GRID_MAX_DEF,
    parameter int START_X        = START_X_DEF,
    parameter int START_Y        = START_Y_DEF
) (
    input  logic               clk,
    input  logic               rst,
    position_tracker_if.slave  bus
);

    localparam int                 TW    = $clog2(TICKS_PER_CELL);
    localparam logic [TW-1:0]      TLAST = TW'(TICKS_PER_CELL - 1);
    localparam int                 SW    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0]      SLOAD = SW'(SETTLE - 1);
    localparam logic [COORD_W-1:0] GMAX  = COORD_W'(GRID_MAX);
    localparam logic [COORD_W-1:0] ONE   = COORD_W'(1);

    pt_state_e          r_state;
    pt_state_e          w_state_nxt;
    logic [TW-1:0]      r_tick_cnt;
    logic [SW-1:0]      r_settle_cnt;
    logic [COORD_W-1:0] r_sx;
    logic [COORD_W-1:0] r_sy;
    logic [COORD_W-1:0] w_sx_step;
    logic [COORD_W-1:0] w_sy_step;
    logic               w_blocked;
    logic               r_step;
    logic               r_clamped;
    logic [1:0]         r_cori_q;
    logic               w_cori_chg;
    logic               w_tick;

    position_tracker_enc_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb (
        .clk    (clk),
        .rst    (rst),
        .i_enc  (bus.enc),
        .o_tick (w_tick)
    );

    assign w_cori_chg = (bus.cori != r_cori_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.turning)     w_state_nxt = ST_TURN;
                else if (bus.moving) w_state_nxt = ST_MOVE;
            end
            ST_MOVE: begin
                if (bus.turning)      w_state_nxt = ST_TURN;
                else if (!bus.moving) w_state_nxt = ST_IDLE;
            end
            ST_TURN: begin
                if (!bus.turning) w_state_nxt = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (bus.turning)              w_state_nxt = ST_TURN;
                else if (r_settle_cnt == '0)  w_state_nxt = bus.moving ? ST_MOVE : ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Candidate coordinates for a step in the current heading, never leaving 0..GRID_MAX.
    always_comb begin
        w_sx_step = r_sx;
        w_sy_step = r_sy;
        w_blocked = 1'b0;
        case (bus.cori)
            ORI_N: if (r_sy == GMAX) w_blocked = 1'b1; else w_sy_step = r_sy + ONE;
            ORI_S: if (r_sy == '0)   w_blocked = 1'b1; else w_sy_step = r_sy - ONE;
            ORI_E: if (r_sx == GMAX) w_blocked = 1'b1; else w_sx_step = r_sx + ONE;
            ORI_W: if (r_sx == '0)   w_blocked = 1'b1; else w_sx_step = r_sx - ONE;
            default: w_blocked = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tick_cnt   <= '0;
            r_settle_cnt <= '0;
            r_sx         <= COORD_W'(START_X);
            r_sy         <= COORD_W'(START_Y);
            r_step       <= 1'b0;
            r_clamped    <= 1'b0;
            r_cori_q     <= 2'b00;
        end else begin
            r_cori_q  <= bus.cori;
            r_step    <= 1'b0;
            r_clamped <= 1'b0;

            if (r_state != ST_SETTLE)  r_settle_cnt <= SLOAD;
            else if (r_settle_cnt != '0) r_settle_cnt <= r_settle_cnt - 1'b1;

            if (bus.load) begin
                r_sx       <= sat_coord(bus.load_x, GMAX);
                r_sy       <= sat_coord(bus.load_y, GMAX);
                r_tick_cnt <= '0;
            end else begin
                case (r_state)
                    ST_MOVE: begin
                        if (bus.turning) begin
                            r_tick_cnt <= '0;
                        end else if (w_cori_chg) begin
                            // A tick coinciding with a heading change is the first of the new heading.
                            r_tick_cnt <= w_tick ? TW'(1) : '0;
                        end else if (w_tick) begin
                            if (r_tick_cnt == TLAST) begin
                                r_tick_cnt <= '0;
                                if (w_blocked) begin
                                    r_clamped <= 1'b1;
                                end else begin
                                    r_sx   <= w_sx_step;
                                    r_sy   <= w_sy_step;
                                    r_step <= 1'b1;
                                end
                            end else begin
                                r_tick_cnt <= r_tick_cnt + 1'b1;
                            end
                        end
                    end
                    ST_TURN: r_tick_cnt <= '0;
                    default: ;
                endcase
            end
        end
    end

    assign bus.sX      = r_sx;
    assign bus.sY      = r_sy;
    assign bus.step    = r_step;
    assign bus.clamped = r_clamped;

endmodule

// File: tb/tb_position_tracker.sv
// Self-checking bench for position_tracker: vector table, directed corner sequences,
// then random segments compared against a per-tick odometry model.
module tb_position_tracker;
    import position_tracker_pkg::*;

    localparam int TPC  = 20;
    localparam int GMX  = 39;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    position_tracker_if bus();

    position_tracker dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec   = 0;
    int n_err   = 0;
    int n_step  = 0;
    int n_clamp = 0;

    always @(negedge clk) begin
        if (!rst && bus.step)    n_step++;
        if (!rst && bus.clamped) n_clamp++;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: time limit reached, got no summary, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Leaves the bench 1 time unit after a rising edge.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int hi, input int lo, input bit bounce);
        if (bounce) begin
            bus.enc = 1'b1; cyc(1);
            bus.enc = 1'b0; cyc(1);
            bus.enc = 1'b1; cyc(1);
        end
        bus.enc = 1'b1; cyc(hi);
        if (bounce) begin
            bus.enc = 1'b0; cyc(1);
            bus.enc = 1'b1; cyc(1);
            bus.enc = 1'b0; cyc(1);
        end
        bus.enc = 1'b0; cyc(lo);
    endtask

    task automatic pulses(input int n, input bit bounce);
        for (int k = 0; k < n; k++) pulse(8, 8, bounce);
    endtask

    task automatic do_load(input longint x, input longint y);
        bus.load_x = COORD_W'(x);
        bus.load_y = COORD_W'(y);
        bus.load   = 1'b1;
        cyc(1);
        bus.load   = 1'b0;
        cyc(2);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.enc = 1'b0; bus.moving = 1'b0; bus.turning = 1'b0; bus.cori = ORI_N;
        bus.load = 1'b0; bus.load_x = '0; bus.load_y = '0;
        cyc(3);
        rst = 1'b0;
        cyc(2);
    endtask

    typedef struct {
        int ld; int lx; int ly; int cori; int n;
        int ex; int ey; int es; int ec;
    } vec_t;

    localparam int NV = 11;
    vec_t tbl [NV];

    // Reference model state
    int mx, my, mcnt, mcori, es, ec;

    task automatic model_tick();
        mcnt++;
        if (mcnt == TPC) begin
            mcnt = 0;
            case (mcori)
                0: if (my == GMX) ec++; else begin my++; es++; end
                3: if (my == 0)   ec++; else begin my--; es++; end
                1: if (mx == GMX) ec++; else begin mx++; es++; end
                default: if (mx == 0) ec++; else begin mx--; es++; end
            endcase
        end
    endtask

    initial begin
        int s0, c0, lat;
        // ld lx ly cori n | ex ey steps clamps
        tbl[0]  = '{0,   0,  0, 0, 20,  0,  1, 1, 0};
        tbl[1]  = '{1,   5, 39, 0, 20,  5, 39, 0, 1};
        tbl[2]  = '{0,   0,  0, 3, 20,  5, 38, 1, 0};
        tbl[3]  = '{1, 100,  7, 1, 20, 39,  7, 0, 1};
        tbl[4]  = '{0,   0,  0, 2, 40, 37,  7, 2, 0};
        tbl[5]  = '{1,   0,  0, 2, 20,  0,  0, 0, 1};
        tbl[6]  = '{0,   0,  0, 3, 20,  0,  0, 0, 1};
        tbl[7]  = '{0,   0,  0, 1, 19,  0,  0, 0, 0};
        tbl[8]  = '{0,   0,  0, 1,  1,  1,  0, 1, 0};
        tbl[9]  = '{1,  39, 39, 0, 20, 39, 39, 0, 1};
        tbl[10] = '{0,   0,  0, 1, 20, 39, 39, 0, 1};

        rst = 1'b1;
        bus.enc = 1'b0; bus.moving = 1'b0; bus.turning = 1'b0; bus.cori = ORI_N;
        bus.load = 1'b0; bus.load_x = '0; bus.load_y = '0;
        cyc(3);
        check("reset sX", longint'(bus.sX), 0);
        check("reset sY", longint'(bus.sY), 0);
        check("reset step", longint'(bus.step), 0);
        check("reset clamped", longint'(bus.clamped), 0);
        rst = 1'b0;
        cyc(2);
        bus.moving = 1'b1;
        cyc(3);

        for (int i = 0; i < NV; i++) begin
            s0 = n_step; c0 = n_clamp;
            if (tbl[i].ld != 0) do_load(longint'(tbl[i].lx), longint'(tbl[i].ly));
            bus.cori = 2'(tbl[i].cori);
            cyc(3);
            pulses(tbl[i].n, 1'b0);
            cyc(4);
            check($sformatf("vec%0d sX", i), longint'(bus.sX), longint'(tbl[i].ex));
            check($sformatf("vec%0d sY", i), longint'(bus.sY), longint'(tbl[i].ey));
            check($sformatf("vec%0d steps", i), longint'(n_step - s0), longint'(tbl[i].es));
            check($sformatf("vec%0d clamps", i), longint'(n_clamp - c0), longint'(tbl[i].ec));
        end

        // Latency: raw rise of the 20th pulse to step pulse is 2+DEBOUNCE+1 cycles
        do_load(0, 0);
        bus.cori = ORI_E; cyc(3);
        pulses(19, 1'b0);
        bus.enc = 1'b1;
        lat = 0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (bus.step && lat == 0) lat = k;
        end
        bus.enc = 1'b0; cyc(10);
        check("latency cycles", longint'(lat), 7);
        check("latency sX", longint'(bus.sX), 1);

        // Bouncing edges: 40 pulses give exactly two cells
        do_load(0, 0);
        bus.cori = ORI_N; cyc(3);
        s0 = n_step;
        pulses(40, 1'b1);
        cyc(4);
        check("bounce sY", longint'(bus.sY), 2);
        check("bounce sX", longint'(bus.sX), 0);
        check("bounce steps", longint'(n_step - s0), 2);

        // Turning discards the partial count and ticks; settle window drops a tick
        do_load(0, 0);
        cyc(2);
        s0 = n_step;
        pulses(10, 1'b0);
        bus.turning = 1'b1; cyc(2);
        pulses(15, 1'b0);
        check("turn sY held", longint'(bus.sY), 0);
        bus.turning = 1'b0;
        bus.enc = 1'b1; cyc(8);
        bus.enc = 1'b0; cyc(12);
        pulses(19, 1'b0);
        cyc(4);
        check("post-turn 19 sY", longint'(bus.sY), 0);
        check("post-turn 19 steps", longint'(n_step - s0), 0);
        pulses(1, 1'b0);
        cyc(4);
        check("post-turn 20 sY", longint'(bus.sY), 1);
        bus.cori = ORI_E; cyc(3);
        pulses(20, 1'b0);
        cyc(4);
        check("turn east sX", longint'(bus.sX), 1);
        check("turn east sY", longint'(bus.sY), 1);
        check("turn steps", longint'(n_step - s0), 2);

        // Load coinciding with the 20th tick wins; tick dropped and count cleared
        do_load(0, 0);
        bus.cori = ORI_N; cyc(3);
        s0 = n_step;
        pulses(19, 1'b0);
        bus.enc = 1'b1; cyc(6);
        bus.load_x = COORD_W'(3); bus.load_y = COORD_W'(4); bus.load = 1'b1;
        cyc(1);
        bus.load = 1'b0;
        check("load+tick step", longint'(bus.step), 0);
        check("load+tick sX", longint'(bus.sX), 3);
        check("load+tick sY", longint'(bus.sY), 4);
        cyc(1);
        bus.enc = 1'b0; cyc(8);
        pulses(19, 1'b0);
        cyc(4);
        check("load+tick 19 sY", longint'(bus.sY), 4);
        pulses(1, 1'b0);
        cyc(4);
        check("load+tick 20 sY", longint'(bus.sY), 5);
        check("load+tick steps", longint'(n_step - s0), 1);

        // Async reset in MOVE with 19 ticks pending
        do_load(10, 10);
        pulses(19, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        check("async rst sX", longint'(bus.sX), 0);
        check("async rst sY", longint'(bus.sY), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        cyc(3);
        s0 = n_step;
        pulses(1, 1'b0);
        cyc(4);
        check("rst tick sY", longint'(bus.sY), 0);
        check("rst tick steps", longint'(n_step - s0), 0);

        // Wide load values saturate on all 33 bits
        do_load(64'h1_0000_0005, 64'h1_0000_0000);
        check("wide load sX", longint'(bus.sX), GMX);
        check("wide load sY", longint'(bus.sY), GMX);

        // Random segments against the model
        do_reset();
        bus.moving = 1'b1; cyc(3);
        mx = 0; my = 0; mcnt = 0; mcori = 0;
        for (int seg = 0; seg < 30; seg++) begin
            int n, lx, ly, nc;
            bit mv, bnc;
            s0 = n_step; c0 = n_clamp;
            es = 0; ec = 0;
            if ($urandom_range(0, 3) == 0) begin
                lx = ($urandom_range(0, 9) == 0) ? 1000 : int'($urandom_range(0, 45));
                ly = ($urandom_range(0, 9) == 0) ? 1000 : int'($urandom_range(0, 45));
                do_load(longint'(lx), longint'(ly));
                mx = (lx > GMX) ? GMX : lx;
                my = (ly > GMX) ? GMX : ly;
                mcnt = 0;
            end
            mv = ($urandom_range(0, 4) != 0);
            bus.moving = mv;
            cyc(3);
            if (mv) begin
                nc = int'($urandom_range(0, 3));
                if (nc != mcori) mcnt = 0;
                mcori = nc;
                bus.cori = 2'(nc);
                cyc(2);
            end
            n = int'($urandom_range(0, 45));
            bnc = 1'($urandom_range(0, 1));
            for (int k = 0; k < n; k++) begin
                pulse(int'($urandom_range(5, 9)), int'($urandom_range(5, 9)), bnc);
                if (mv) model_tick();
            end
            cyc(4);
            check($sformatf("rand%0d sX", seg), longint'(bus.sX), longint'(mx));
            check($sformatf("rand%0d sY", seg), longint'(bus.sY), longint'(my));
            check($sformatf("rand%0d steps", seg), longint'(n_step - s0), longint'(es));
            check($sformatf("rand%0d clamps", seg), longint'(n_clamp - c0), longint'(ec));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
